alu_exec_wb: RTL and testbench

Two-stage execute/writeback stage for the 8-bit datapath: accepts one operation per handshake and reads its operands from a 4-entry register file. It evaluates the operation through the functional-unit bank, then writes the result back and updates the condition-code register (C,V,N,Z). It sits directly downstream of the FU bank: it feeds the FUs their operands and consumes their result and flag outputs.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/fu_bank_sel.sv | 82 ++++++++
 rtl/alu_exec_wb.sv | 104 ++++++++++
 tb/tb_alu_exec_wb.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit execute/writeback datapath: opcodes,
// condition-code layout and opcode decode helpers.
package alu_pkg;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_INC    = 4'h2;
    localparam logic [3:0] OP_NEG    = 4'h3;
    localparam logic [3:0] OP_NAND   = 4'h4;
    localparam logic [3:0] OP_XNOR   = 4'h5;
    localparam logic [3:0] OP_NOT    = 4'h6;
    localparam logic [3:0] OP_BMUL4  = 4'h7;
    localparam logic [3:0] OP_BDIV16 = 4'h8;
    localparam logic [3:0] OP_BMOD16 = 4'h9;
    localparam logic [3:0] OP_ROL    = 4'hA;
    localparam logic [3:0] OP_ROR    = 4'hB;
    localparam logic [3:0] OP_LDI    = 4'hC;

    localparam int CCR_C = 3;
    localparam int CCR_V = 2;
    localparam int CCR_N = 1;
    localparam int CCR_Z = 0;

    // Field order matches the CCR bit indices above.
    typedef struct packed {
        logic c;
        logic v;
        logic n;
        logic z;
    } flags_t;

    function automatic logic is_illegal(input logic [3:0] op);
        return op > OP_LDI;
    endfunction

    function automatic logic writes_reg(input logic [3:0] op);
        return !is_illegal(op);
    endfunction

endpackage

// File: rtl/fu_bank_sel.sv
// Combinational functional-unit bank: evaluates one opcode on A/B/imm and
// produces the 8-bit result with its {C,V,N,Z} flags.
module fu_bank_sel
    import alu_pkg::*;
(
    input  logic [3:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] imm,
    output logic [7:0] result,
    output flags_t     flags
);

    logic [7:0] bNot;
    logic [8:0] sum9;
    logic [7:0] low8;
    logic       carry;
    logic       ovf;
    logic       nzEn;

    assign bNot = ~b;

    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        result = '0;
        sum9   = '0;
        low8   = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        nzEn   = 1'b1;
        case (op)
            OP_ADD: begin
                sum9   = {1'b0, a} + {1'b0, b};
                low8   = {1'b0, a[6:0]} + {1'b0, b[6:0]};
                result = sum9[7:0];
                carry  = sum9[8];
                ovf    = sum9[8] ^ low8[7];
            end
            OP_SUB: begin
                // low8[7] is the carry into bit 7, sum9[8] the carry out.
                sum9   = {1'b0, a} + {1'b0, bNot} + 9'd1;
                low8   = {1'b0, a[6:0]} + {1'b0, bNot[6:0]} + 8'd1;
                result = sum9[7:0];
                carry  = ~sum9[8];
                ovf    = sum9[8] ^ low8[7];
            end
            OP_INC: begin
                sum9   = {1'b0, a} + 9'd1;
                result = sum9[7:0];
                carry  = sum9[8];
                ovf    = (a == 8'h7F);
            end
            OP_NEG: begin
                result = ~a + 8'd1;
                carry  = (a == 8'h00);
                ovf    = (a == 8'h80);
            end
            OP_NAND:   result = ~(a & b);
            OP_XNOR:   result = ~(a ^ b);
            OP_NOT:    result = ~a;
            OP_BMUL4:  result = {b[5:0], 2'b00};
            OP_BDIV16: result = {{4{b[7]}}, b[7:4]};
            OP_BMOD16: result = {4'h0, b[3:0]};
            OP_ROL: begin
                result = {b[6:0], b[7]};
                nzEn   = 1'b0;
            end
            OP_ROR: begin
                result = {b[0], b[7:1]};
                nzEn   = 1'b0;
            end
            OP_LDI:    result = imm;
            default:   nzEn = 1'b0;
        endcase
        flags.c = carry;
        flags.v = ovf;
        flags.n = nzEn & result[7];
        flags.z = nzEn & (result == 8'h00);
    end

endmodule

// File: rtl/alu_exec_wb.sv
// Execute/writeback stage: register file, operand forwarding, one EX
// register feeding the FU bank, valid/ready handshake and the CCR.
module alu_exec_wb
    import alu_pkg::*;
#(
    parameter int NREG = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_op,
    input  logic [$clog2(NREG)-1:0] in_rd,
    input  logic [$clog2(NREG)-1:0] in_ra,
    input  logic [$clog2(NREG)-1:0] in_rb,
    input  logic [7:0]              in_imm,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(NREG)-1:0] out_rd,
    output logic [7:0]              out_result,
    output logic [3:0]              out_flags,
    output logic [3:0]              ccr,
    output logic                    err_illegal,
    input  logic [$clog2(NREG)-1:0] dbg_sel,
    output logic [7:0]              dbg_data
);

    localparam int RW = $clog2(NREG);

    logic [7:0]    rf [NREG];
    logic          exValid;
    logic [3:0]    exOp;
    logic [RW-1:0] exRd;
    logic [7:0]    exA;
    logic [7:0]    exB;
    logic [7:0]    exImm;
    logic [7:0]    fuResult;
    flags_t        fuFlags;
    logic          exWrites;
    logic          accept;
    logic          commit;
    logic [7:0]    opA;
    logic [7:0]    opB;

    fu_bank_sel u_fu (
        .op     (exOp),
        .a      (exA),
        .b      (exB),
        .imm    (exImm),
        .result (fuResult),
        .flags  (fuFlags)
    );

    assign in_ready = !exValid || out_ready;
    assign accept   = in_valid && in_ready;
    assign commit   = exValid && out_ready;
    assign exWrites = exValid && writes_reg(exOp);

    // The register file is not yet updated on a commit edge, so the EX
    // result must be forwarded even when that op commits this cycle.
    assign opA = (exWrites && exRd == in_ra) ? fuResult : rf[in_ra];
    assign opB = (exWrites && exRd == in_rb) ? fuResult : rf[in_rb];

    assign out_valid  = exValid;
    assign out_rd     = exRd;
    assign out_result = fuResult;
    assign out_flags  = (is_illegal(exOp) || exOp == OP_LDI) ? ccr : fuFlags;
    assign dbg_data   = rf[dbg_sel];

    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the small register file is architecturally cleared by
            // reset, so it lives in flops with an async reset, not a RAM.
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
            exValid     <= 1'b0;
            exOp        <= '0;
            exRd        <= '0;
            exA         <= '0;
            exB         <= '0;
            exImm       <= '0;
            ccr         <= '0;
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= commit && is_illegal(exOp);
            if (commit) begin
                if (writes_reg(exOp)) rf[exRd] <= fuResult;
                ccr <= out_flags;
            end
            if (accept) begin
                exValid <= 1'b1;
                exOp    <= in_op;
                exRd    <= in_rd;
                exA     <= opA;
                exB     <= opB;
                exImm   <= in_imm;
            end else if (commit) begin
                exValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_wb.sv
// Directed bench for alu_exec_wb: forwarding, flag rules, stall, illegal
// opcode and mid-operation reset, with hand-computed expected values.
module tb_alu_exec_wb;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_op = '0;
    logic [1:0] in_rd = '0;
    logic [1:0] in_ra = '0;
    logic [1:0] in_rb = '0;
    logic [7:0] in_imm = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [1:0] out_rd;
    logic [7:0] out_result;
    logic [3:0] out_flags;
    logic [3:0] ccr;
    logic       err_illegal;
    logic [1:0] dbg_sel = '0;
    logic [7:0] dbg_data;

    int nCompared = 0;
    int nMismatched = 0;

    alu_exec_wb #(.NREG(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_result(out_result), .out_flags(out_flags), .ccr(ccr),
        .err_illegal(err_illegal), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Present one op at a falling edge and return just after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [1:0] rd,
                         input logic [1:0] ra, input logic [1:0] rb, input logic [7:0] imm);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_ra = ra; in_rb = rb; in_imm = imm;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        nCompared++;
        if (!in_ready) begin
            nMismatched++;
            $display("FAIL issue_timeout: in_ready %b required 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        @(negedge clk);
        while (out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        nCompared++;
        if (out_valid) begin
            nMismatched++;
            $display("FAIL drain_timeout: out_valid %b required 0", out_valid);
        end
    endtask

    task automatic readReg(input logic [1:0] idx, output logic [7:0] v);
        dbg_sel = idx;
        #1 v = dbg_data;
    endtask

    task automatic checkResetState(input string tag);
        logic [7:0] v;
        nCompared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ccr !== 4'h0 || err_illegal !== 1'b0) begin
            nMismatched++;
            $display("FAIL %s_ctrl: out_valid=%b in_ready=%b ccr=%h err=%b required 0 1 0 0",
                     tag, out_valid, in_ready, ccr, err_illegal);
        end
        for (int i = 0; i < 4; i++) begin
            readReg(2'(i), v);
            nCompared++;
            if (v !== 8'h00) begin
                nMismatched++;
                $display("FAIL %s_r%0d: got %h required 00", tag, i, v);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkResetState("reset");
    endtask

    task automatic test_forward();
        logic [7:0] v;
        out_ready = 1'b1;
        issue(OP_LDI, 2'd0, 2'd0, 2'd0, 8'h7F);
        issue(OP_INC, 2'd1, 2'd0, 2'd0, 8'h00);
        drain();
        readReg(2'd1, v);
        nCompared++;
        if (v !== 8'h80) begin nMismatched++; $display("FAIL fwd_inc_r1: got %h required 80", v); end
        nCompared++;
        if (ccr !== 4'b0110) begin nMismatched++; $display("FAIL fwd_inc_ccr: got %b required 0110", ccr); end
    endtask

    task automatic test_sub();
        logic [7:0] v;
        issue(OP_LDI, 2'd0, 2'd0, 2'd0, 8'h05);
        issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h07);
        issue(OP_SUB, 2'd2, 2'd0, 2'd1, 8'h00);
        drain();
        readReg(2'd2, v);
        nCompared++;
        if (v !== 8'hFE) begin nMismatched++; $display("FAIL sub_r2: got %h required FE", v); end
        nCompared++;
        if (ccr !== 4'b1010) begin nMismatched++; $display("FAIL sub_ccr: got %b required 1010", ccr); end
    endtask

    task automatic test_add_neg();
        logic [7:0] v;
        issue(OP_LDI, 2'd0, 2'd0, 2'd0, 8'h80);
        issue(OP_ADD, 2'd3, 2'd0, 2'd0, 8'h00);
        drain();
        readReg(2'd3, v);
        nCompared++;
        if (v !== 8'h00) begin nMismatched++; $display("FAIL add_r3: got %h required 00", v); end
        nCompared++;
        if (ccr !== 4'b1101) begin nMismatched++; $display("FAIL add_ccr: got %b required 1101", ccr); end
        issue(OP_NEG, 2'd2, 2'd0, 2'd0, 8'h00);
        drain();
        readReg(2'd2, v);
        nCompared++;
        if (v !== 8'h80) begin nMismatched++; $display("FAIL neg_r2: got %h required 80", v); end
        nCompared++;
        if (ccr !== 4'b0110) begin nMismatched++; $display("FAIL neg_ccr: got %b required 0110", ccr); end
    endtask

    // r2 holds 0x80 and ccr is 0110 on entry.
    task automatic test_stall();
        logic [7:0] v;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = OP_LDI; in_rd = 2'd1; in_ra = 2'd0; in_rb = 2'd0; in_imm = 8'h11;
        @(posedge clk);
        #1 in_op = OP_ADD; in_rd = 2'd2; in_ra = 2'd1; in_rb = 2'd1; in_imm = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nCompared++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_rd !== 2'd1 ||
                out_result !== 8'h11 || out_flags !== 4'b0110) begin
                nMismatched++;
                $display("FAIL stall_hold%0d: rdy=%b ov=%b rd=%0d res=%h fl=%b required 0 1 1 11 0110",
                         i, in_ready, out_valid, out_rd, out_result, out_flags);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        nCompared++;
        if (out_valid !== 1'b1 || out_rd !== 2'd2 || out_result !== 8'h22) begin
            nMismatched++;
            $display("FAIL stall_second: ov=%b rd=%0d res=%h required 1 2 22", out_valid, out_rd, out_result);
        end
        readReg(2'd1, v);
        nCompared++;
        if (v !== 8'h11) begin nMismatched++; $display("FAIL stall_r1: got %h required 11", v); end
        readReg(2'd2, v);
        nCompared++;
        if (v !== 8'h80) begin nMismatched++; $display("FAIL stall_r2_early: got %h required 80", v); end
        @(posedge clk);
        #1 readReg(2'd2, v);
        nCompared++;
        if (v !== 8'h22 || out_valid !== 1'b0) begin
            nMismatched++;
            $display("FAIL stall_r2: got %h ov=%b required 22 0", v, out_valid);
        end
        nCompared++;
        if (ccr !== 4'b0000) begin nMismatched++; $display("FAIL stall_ccr: got %b required 0000", ccr); end
    endtask

    task automatic test_shift();
        logic [7:0] v;
        issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h90);
        issue(OP_BDIV16, 2'd2, 2'd0, 2'd1, 8'h00);
        drain();
        readReg(2'd2, v);
        nCompared++;
        if (v !== 8'hF9 || ccr !== 4'b0010) begin
            nMismatched++;
            $display("FAIL bdiv16: got %h ccr %b required F9 0010", v, ccr);
        end
        issue(OP_BMOD16, 2'd3, 2'd0, 2'd1, 8'h00);
        drain();
        readReg(2'd3, v);
        nCompared++;
        if (v !== 8'h00 || ccr !== 4'b0001) begin
            nMismatched++;
            $display("FAIL bmod16: got %h ccr %b required 00 0001", v, ccr);
        end
        issue(OP_LDI, 2'd0, 2'd0, 2'd0, 8'h81);
        drain();
        nCompared++;
        if (ccr !== 4'b0001) begin nMismatched++; $display("FAIL ldi_keeps_ccr: got %b required 0001", ccr); end
        issue(OP_ROL, 2'd0, 2'd0, 2'd0, 8'h00);
        drain();
        readReg(2'd0, v);
        nCompared++;
        if (v !== 8'h03 || ccr !== 4'b0000) begin
            nMismatched++;
            $display("FAIL rol: got %h ccr %b required 03 0000", v, ccr);
        end
    endtask

    // r0=03 r1=90 on entry.
    task automatic test_illegal();
        logic [7:0] v;
        int pulses = 0;
        issue(OP_SUB, 2'd3, 2'd0, 2'd1, 8'h00);
        drain();
        readReg(2'd3, v);
        nCompared++;
        if (v !== 8'h73 || ccr !== 4'b1000) begin
            nMismatched++;
            $display("FAIL pre_illegal_sub: got %h ccr %b required 73 1000", v, ccr);
        end
        issue(4'hE, 2'd0, 2'd0, 2'd1, 8'h00);
        nCompared++;
        if (out_valid !== 1'b1 || out_flags !== 4'b1000) begin
            nMismatched++;
            $display("FAIL illegal_pending: ov=%b fl=%b required 1 1000", out_valid, out_flags);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (err_illegal === 1'b1) pulses++;
        end
        nCompared++;
        if (pulses != 1) begin nMismatched++; $display("FAIL illegal_pulse: got %0d pulses required 1", pulses); end
        readReg(2'd0, v);
        nCompared++;
        if (v !== 8'h03 || ccr !== 4'b1000) begin
            nMismatched++;
            $display("FAIL illegal_nowrite: r0 %h ccr %b required 03 1000", v, ccr);
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = OP_LDI; in_rd = 2'd2; in_ra = 2'd0; in_rb = 2'd0; in_imm = 8'h55;
        @(posedge clk);
        #1 in_valid = 1'b0;
        nCompared++;
        if (out_valid !== 1'b1) begin nMismatched++; $display("FAIL midop_pending: ov=%b required 1", out_valid); end
        #2 rst_n = 1'b0;
        #1 checkResetState("midop");
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkResetState("postrst");
    endtask

    initial begin
        test_reset();
        test_forward();
        test_sub();
        test_add_neg();
        test_stall();
        test_shift();
        test_illegal();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
